// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : 8N1 UART transmitter shared by two requesters, round-robin on ties.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
    parameter logic [31:0] DEFAULT_DIV = 32'd106
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_div_we,
    input  logic [31:0] cfg_div_di,
    output logic [31:0] cfg_div_do,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        ser_tx,
    output logic        busy,
    output logic        last_grant
);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_start = 2'd1;
    localparam logic [1:0]  c_st_data  = 2'd2;
    localparam logic [1:0]  c_st_stop  = 2'd3;
    localparam logic [31:0] c_min_div  = 32'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_div;
    logic [31:0] r_div_eff;
    logic [9:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic [31:0] r_cnt;
    logic        r_last_grant;
    logic        w_grant_any;
    logic        w_grant_idx;
    logic        w_bit_end;
    logic [7:0]  w_data_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Reset gates the grant so neither ready rises during the reset cycle.
    always_comb begin
        w_grant_any  = 1'b0;
        w_grant_idx  = r_last_grant;
        w_state_next = r_state;
        w_bit_end    = (r_cnt == (r_div_eff - 32'd1));
        if ((r_state == c_st_idle) && !reset) begin
            if (req0_valid && req1_valid) begin
                w_grant_any = 1'b1;
                w_grant_idx = ~r_last_grant;
            end else if (req0_valid) begin
                w_grant_any = 1'b1;
                w_grant_idx = 1'b0;
            end else if (req1_valid) begin
                w_grant_any = 1'b1;
                w_grant_idx = 1'b1;
            end
        end
        case (r_state)
            c_st_idle:  if (w_grant_any) w_state_next = c_st_start;
            c_st_start: if (w_bit_end) w_state_next = c_st_data;
            c_st_data:  if (w_bit_end && (r_bit_cnt == 3'd7)) w_state_next = c_st_stop;
            c_st_stop:  if (w_bit_end) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    assign w_data_sel = w_grant_idx ? req1_data : req0_data;

    // The divider is snapshotted at acceptance so later writes only affect the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div        <= DEFAULT_DIV;
            r_div_eff    <= c_min_div;
            r_shift      <= '1;
            r_bit_cnt    <= 3'd0;
            r_cnt        <= 32'd0;
            r_last_grant <= 1'b1;
        end else begin
            if (cfg_div_we) begin
                r_div <= cfg_div_di;
            end
            if (r_state == c_st_idle) begin
                r_cnt     <= 32'd0;
                r_bit_cnt <= 3'd0;
                if (w_grant_any) begin
                    r_shift      <= {1'b1, w_data_sel, 1'b0};
                    r_last_grant <= w_grant_idx;
                    r_div_eff    <= (r_div < c_min_div) ? c_min_div : r_div;
                end
            end else if (w_bit_end) begin
                r_cnt   <= 32'd0;
                r_shift <= {1'b1, r_shift[9:1]};
                if (r_state == c_st_data) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign req0_ready = w_grant_any && !w_grant_idx;
    assign req1_ready = w_grant_any &&  w_grant_idx;
    assign ser_tx     = (r_state == c_st_idle) ? 1'b1 : r_shift[0];
    assign busy       = (r_state != c_st_idle);
    assign last_grant = r_last_grant;
    assign cfg_div_do = r_div;

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter DEFAULT_DIV, default 106, SHALL set the bit period in clk cycles used when cfg_div_we has never been asserted since reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset, sampled on rising clk.
REQ-004 cfg_div_we  input  1  SHALL load cfg_div_di into the divider register when high.
REQ-005 cfg_div_di  input  32  SHALL be the new bit period in clk cycles.
REQ-006 cfg_div_do  output  32  SHALL reflect the current divider register.
REQ-007 req0_valid  input  1  SHALL indicate that requester 0 (CPU) offers req0_data.
REQ-008 req0_data  input  8  SHALL be the byte offered by requester 0.
REQ-009 req0_ready  output  1  SHALL indicate that requester 0's byte is accepted this cycle.
REQ-010 req1_valid, req1_data[7:0], req1_ready SHALL behave as REQ-007..009 for requester 1 (debug).
REQ-011 ser_tx  output  1  SHALL be the serial line, idle high.
REQ-012 busy  output  1  SHALL be high whenever state != IDLE.
REQ-013 last_grant  output  1  SHALL hold the index of the requester most recently served.

Function
REQ-014 States SHALL be IDLE, START, DATA, STOP; each bit state SHALL last exactly div_eff cycles.
REQ-015 div_eff SHALL equal the divider latched at byte acceptance, clamped to a minimum of 2; a divider write mid-frame SHALL NOT affect the current frame.
REQ-016 In IDLE: if exactly one valid is high, that requester SHALL be granted; if both are high, the one != last_grant SHALL be granted; if neither is high, no grant.
REQ-017 reqN_ready SHALL be combinational: high only in IDLE, only for the granted requester, only while its valid is high; never both high.
REQ-018 Transfer SHALL occur on a cycle with valid && ready; data SHALL be captured into a 10-bit shift register {1, data, 0}, last_grant updated, and state -> START on the next edge.
REQ-019 ser_tx SHALL go low on the cycle after the transfer (START), then carry data bits LSB first, one per div_eff cycles, in DATA.
REQ-020 STOP SHALL drive ser_tx high for div_eff cycles, then return to IDLE; a frame SHALL occupy exactly 10*div_eff cycles from ser_tx falling edge to return to IDLE.
REQ-021 A new transfer SHALL be possible on the first IDLE cycle after STOP (back-to-back frames, no extra idle gap).
REQ-022 Bit counter SHALL count 0..7 in DATA and exit to STOP after bit 7; bit-period counter SHALL be 32 bits and SHALL NOT wrap within a bit.
REQ-023 A requester that drops valid before ready SHALL lose the grant without consuming a frame; data SHALL NOT be required stable before ready.
REQ-024 cfg_div_we during a transfer cycle SHALL take effect for the next frame only; the current frame SHALL use the old value.

Reset
REQ-025 On reset: state IDLE, ser_tx 1, busy 0, req0_ready/req1_ready 0 in the reset cycle, last_grant 1 (so req0 wins the first tie), divider = DEFAULT_DIV, counters 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame, force ser_tx high on the next edge, and discard the byte with no retransmit.

Verification
REQ-027 Reset, req0 sends 0x41 with DEFAULT_DIV -> ser_tx low 1 cycle after accept; bits sampled at 53+106k cycles read 0x41; busy low 1060 cycles after falling edge.
REQ-028 Both valid continuously, req0=0x30, req1=0x31, 3 frames -> order '0','1','0'; last_grant toggles 0,1,0; never both ready.
REQ-029 cfg_div_di=2 written, send 0x55 -> ser_tx toggles every 2 cycles for the data bits; frame = 20 cycles; back-to-back second byte starts on cycle 21.
REQ-030 cfg_div_di=0 -> div_eff=2, frame 20 cycles; cfg_div_do reads 0.
REQ-031 Divider written to 10 during a frame with divider 106 -> current frame remains 1060 cycles, next frame 100 cycles.
REQ-032 Reset pulsed at DATA bit 3 -> ser_tx high next cycle, busy 0, req0_ready asserts again with next valid; no partial stop bit.
